// File: rtl/iob_fifo_sync_ctrl_pkg.sv
// Shared sizing constants and helpers for the synchronous FIFO controller.
package iob_fifo_sync_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Depth is a power of two so the pointers can wrap freely.
  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // One extra bit so the level can represent the completely full state.
  function automatic int level_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/iob_fifo_sync_ctrl_if.sv
// User-side push/pop interface of the FIFO controller.
interface iob_fifo_sync_ctrl_if
  import iob_fifo_sync_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                           w_en;
  logic [DATA_W-1:0]              w_data;
  logic                           w_full;
  logic                           r_en;
  logic [DATA_W-1:0]              r_data;
  logic                           r_data_valid;
  logic                           r_empty;
  logic [level_width(ADDR_W)-1:0] level;

  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_data_valid, r_empty, level
  );

  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_data_valid, r_empty, level
  );

endinterface

// File: rtl/iob_fifo_sync_ctrl_ptr.sv
// Wrapping FIFO address pointer with increment enable and synchronous clear.
module iob_fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/iob_ram_2p_be.sv
// Two-port RAM with registered, read-enable-gated output; the controller's external memory.
module iob_ram_2p_be #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_w_en,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_r_en,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic [DATA_W-1:0] o_r_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto a RAM macro; only the read register holds state.
  always_ff @(posedge clk) begin
    if (i_w_en) begin
      r_mem[i_w_addr] <= i_w_data;
    end
    if (i_r_en) begin
      r_rdata <= r_mem[i_r_addr];
    end
  end

  assign o_r_data = r_rdata;

endmodule

// File: rtl/iob_fifo_sync_ctrl.sv
// Synchronous FIFO controller driving an external two-port RAM; tracks level and flags.
module iob_fifo_sync_ctrl
  import iob_fifo_sync_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rst,
  iob_fifo_sync_ctrl_if.slave   fifo_if,
  output logic                  ext_mem_w_en,
  output logic [ADDR_W-1:0]     ext_mem_w_addr,
  output logic [DATA_W-1:0]     ext_mem_w_data,
  output logic                  ext_mem_r_en,
  output logic [ADDR_W-1:0]     ext_mem_r_addr,
  input  logic [DATA_W-1:0]     ext_mem_r_data
);

  localparam int                  FIFO_DEPTH = fifo_depth(ADDR_W);
  localparam int                  LEVEL_W    = level_width(ADDR_W);
  localparam logic [LEVEL_W-1:0]  FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_wptr;
  logic [ADDR_W-1:0]  w_rptr;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [LEVEL_W-1:0] r_level;
  logic               r_empty;
  logic               r_full;
  logic               r_data_valid;

  // A synchronous clear must also keep the RAM untouched in that cycle.
  assign w_push = fifo_if.w_en & ~r_full  & ~rst;
  assign w_pop  = fifo_if.r_en & ~r_empty & ~rst;

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk   (clk),
    .arst  (arst),
    .i_clr (rst),
    .i_en  (w_push),
    .o_ptr (w_wptr)
  );

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk   (clk),
    .arst  (arst),
    .i_clr (rst),
    .i_en  (w_pop),
    .o_ptr (w_rptr)
  );

  // NOTE: the default assignment up front keeps this combinational block from inferring a latch.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags come from the next level so they are registered yet never lag the level.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_level      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_data_valid <= 1'b0;
    end else if (rst) begin
      r_level      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_level      <= w_level_nxt;
      r_empty      <= (w_level_nxt == '0);
      r_full       <= (w_level_nxt == FULL_LEVEL);
      r_data_valid <= w_pop;
    end
  end

  assign ext_mem_w_en   = w_push;
  assign ext_mem_w_addr = w_wptr;
  assign ext_mem_w_data = fifo_if.w_data;
  assign ext_mem_r_en   = w_pop;
  assign ext_mem_r_addr = w_rptr;

  assign fifo_if.r_data       = ext_mem_r_data;
  assign fifo_if.r_data_valid = r_data_valid;
  assign fifo_if.r_empty      = r_empty;
  assign fifo_if.w_full       = r_full;
  assign fifo_if.level        = r_level;

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Self-checking bench: FIFO controller plus RAM, queue reference model and data scoreboard.
module tb_iob_fifo_sync_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef struct {
    logic             we;
    logic [DATA_W-1:0] wd;
    logic             re;
    logic             rs;
    int               exp_level;
    logic             exp_empty;
    logic             exp_full;
  } vec_t;

  logic clk = 1'b0;
  logic arst;
  logic rst;

  logic              ext_mem_w_en;
  logic [ADDR_W-1:0] ext_mem_w_addr;
  logic [DATA_W-1:0] ext_mem_w_data;
  logic              ext_mem_r_en;
  logic [ADDR_W-1:0] ext_mem_r_addr;
  logic [DATA_W-1:0] ext_mem_r_data;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iob_fifo_sync_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fifo_if ();

  iob_fifo_sync_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .arst           (arst),
    .rst            (rst),
    .fifo_if        (fifo_if),
    .ext_mem_w_en   (ext_mem_w_en),
    .ext_mem_w_addr (ext_mem_w_addr),
    .ext_mem_w_data (ext_mem_w_data),
    .ext_mem_r_en   (ext_mem_r_en),
    .ext_mem_r_addr (ext_mem_r_addr),
    .ext_mem_r_data (ext_mem_r_data)
  );

  iob_ram_2p_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .i_w_en   (ext_mem_w_en),
    .i_w_addr (ext_mem_w_addr),
    .i_w_data (ext_mem_w_data),
    .i_r_en   (ext_mem_r_en),
    .i_r_addr (ext_mem_r_addr),
    .o_r_data (ext_mem_r_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 32'(fifo_if.level), 32'(mq.size()));
    check({tag, "_empty"}, 32'(fifo_if.r_empty), 32'(mq.size() == 0));
    check({tag, "_full"},  32'(fifo_if.w_full),  32'(mq.size() == DEPTH));
  endtask

  // One clock of stimulus; the model decides acceptance, the scoreboard checks popped data.
  task automatic cycle(input logic we, input logic [DATA_W-1:0] wd, input logic re, input logic rs);
    logic acc_w;
    logic acc_r;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    fifo_if.w_en   = we;
    fifo_if.w_data = wd;
    fifo_if.r_en   = re;
    rst            = rs;
    acc_w = we && !rs && (mq.size() < DEPTH);
    acc_r = re && !rs && (mq.size() > 0);
    if (acc_r) exp_q.push_back(mq[0]);
    #1;
    check("mem_w_en", 32'(ext_mem_w_en), 32'(acc_w));
    check("mem_r_en", 32'(ext_mem_r_en), 32'(acc_r));
    if (acc_w) check("mem_w_data", 32'(ext_mem_w_data), 32'(wd));
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
    end else begin
      if (acc_r) void'(mq.pop_front());
      if (acc_w) mq.push_back(wd);
    end
    check("r_data_valid", 32'(fifo_if.r_data_valid), 32'(acc_r));
    if (acc_r) begin
      exp_d = exp_q.pop_front();
      if (fifo_if.r_data_valid) check("r_data", 32'(fifo_if.r_data), 32'(exp_d));
    end
    check_state("cyc");
  endtask

  task automatic idle_inputs();
    fifo_if.w_en   = 1'b0;
    fifo_if.w_data = '0;
    fifo_if.r_en   = 1'b0;
    rst            = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1'b1, 8'd7, 1'b1, 1'b0, 1, 1'b0, 1'b0};  // empty: push wins, no fall-through
    tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0};  // pops the 7
    tbl[2] = '{1'b0, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0};  // pop on empty ignored
    tbl[3] = '{1'b1, 8'd3, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'd4, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'd5, 1'b1, 1'b0, 2, 1'b0, 1'b0};  // pops the 3
    tbl[6] = '{1'b1, 8'd6, 1'b0, 1'b1, 0, 1'b1, 1'b0};  // sync clear beats push
    tbl[7] = '{1'b0, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0};

    idle_inputs();
    arst = 1'b1;
    #12;
    check("rst_level", 32'(fifo_if.level), 32'd0);
    check("rst_empty", 32'(fifo_if.r_empty), 32'd1);
    check("rst_full",  32'(fifo_if.w_full), 32'd0);
    check("rst_valid", 32'(fifo_if.r_data_valid), 32'd0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].rs);
      check("tbl_level", 32'(fifo_if.level), 32'(tbl[i].exp_level));
      check("tbl_empty", 32'(fifo_if.r_empty), 32'(tbl[i].exp_empty));
      check("tbl_full",  32'(fifo_if.w_full), 32'(tbl[i].exp_full));
    end

    // Fill, rejected 17th push, drain, extra pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(32 + i), 1'b0, 1'b0);
    check("fill_level", 32'(fifo_if.level), 32'd16);
    check("fill_full",  32'(fifo_if.w_full), 32'd1);
    cycle(1'b1, 8'd99, 1'b0, 1'b0);
    check("over_level", 32'(fifo_if.level), 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    check("drain_level", 32'(fifo_if.level), 32'd0);
    check("drain_empty", 32'(fifo_if.r_empty), 32'd1);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Steady simultaneous push/pop at level 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(110 + i), 1'b1, 1'b0);
      check("steady_level", 32'(fifo_if.level), 32'd5);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Full boundary: pop wins
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i * 3 + 1), 1'b0, 1'b0);
    cycle(1'b1, 8'd200, 1'b1, 1'b0);
    check("fullb_level", 32'(fifo_if.level), 32'd15);
    check("fullb_full",  32'(fifo_if.w_full), 32'd0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("wrap_full", 32'(fifo_if.w_full), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    check("wrap_empty", 32'(fifo_if.r_empty), 32'd1);

    // Synchronous clear at level 6 with a push pending
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(70 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    check("srst_level", 32'(fifo_if.level), 32'd0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Async reset mid-cycle while a pop is being requested
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(80 + i), 1'b0, 1'b0);
    @(negedge clk);
    fifo_if.r_en = 1'b1;
    #2;
    arst = 1'b1;
    #1;
    check("arst_level", 32'(fifo_if.level), 32'd0);
    check("arst_empty", 32'(fifo_if.r_empty), 32'd1);
    check("arst_mem_r_en", 32'(ext_mem_r_en), 32'd0);
    @(posedge clk);
    #1;
    check("arst_valid", 32'(fifo_if.r_data_valid), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    idle_inputs();
    mq.delete();

    // Async reset drops an in-flight valid
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    #1;
    arst = 1'b1;
    #1;
    check("arst_drop_valid", 32'(fifo_if.r_data_valid), 32'd0);
    check("arst_drop_level", 32'(fifo_if.level), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    idle_inputs();
    mq.delete();

    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
